// File: rtl/matmul_sched_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply job scheduler.
// Matrices are flattened row-major with element 00 at the LSBs.
package matmul_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDone
  } state_e;

  localparam int unsigned N        = 3;
  localparam int unsigned NUM_ELEM = N * N;

  // Bit offset of element (row, col) in a flattened matrix of width-bit elements.
  function automatic int unsigned elem_offset(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned width);
    return (row * N + col) * width;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; purely combinational, the last grant is held by the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      // On a tie the requester that did not win last time goes first.
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Shares one 3x3 matrix_mult between two requesters: round-robin accept, clear,
// run for LATENCY cycles, capture C and hold it on the response port.
module matmul_job_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int unsigned BitWidth = 8,
  parameter int unsigned LATENCY  = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req0_valid,
  output logic                           req0_ready,
  input  logic [NUM_ELEM*BitWidth-1:0]   req0_a,
  input  logic [NUM_ELEM*BitWidth-1:0]   req0_b,
  input  logic                           req1_valid,
  output logic                           req1_ready,
  input  logic [NUM_ELEM*BitWidth-1:0]   req1_a,
  input  logic [NUM_ELEM*BitWidth-1:0]   req1_b,
  output logic                           mm_reset,
  output logic                           mm_enable,
  output logic [NUM_ELEM*BitWidth-1:0]   mm_a,
  output logic [NUM_ELEM*BitWidth-1:0]   mm_b,
  input  logic [NUM_ELEM*2*BitWidth-1:0] mm_c,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [NUM_ELEM*2*BitWidth-1:0] rsp_data,
  output logic                           rsp_id,
  output logic                           busy
);

  localparam int unsigned AW = NUM_ELEM * BitWidth;
  localparam int unsigned CW = NUM_ELEM * 2 * BitWidth;
  localparam logic [7:0]  CntLoad = 8'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;
  logic [AW-1:0]   a_q, a_d;
  logic [AW-1:0]   b_q, b_d;
  logic [CW-1:0]   data_q, data_d;
  logic            id_q, id_d;
  logic [1:0]      gnt;
  logic            accept;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign req0_ready = (state_q == StIdle) && !reset && gnt[0];
  assign req1_ready = (state_q == StIdle) && !reset && gnt[1];
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    id_d         = id_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d          = gnt[1] ? req1_a : req0_a;
          b_d          = gnt[1] ? req1_b : req0_b;
          id_d         = gnt[1];
          last_grant_d = gnt[1];
          state_d      = StClear;
        end
      end
      StClear: begin
        cnt_d   = CntLoad;
        state_d = StRun;
      end
      StRun: begin
        // Counter hits zero on the LATENCY-th enabled cycle; C is valid then.
        if (cnt_q == 8'd0) begin
          data_d  = mm_c;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
      id_q         <= id_d;
    end
  end

  // The multiplier is held in reset both by our own reset and for the flush cycle.
  assign mm_reset  = reset || (state_q == StClear);
  assign mm_enable = (state_q == StRun);
  assign mm_a      = a_q;
  assign mm_b      = b_q;
  assign rsp_valid = (state_q == StDone);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != StIdle);

endmodule
